vga_line_arbiter: RTL and testbench
===================================

VGA_LINE_ARBITER -- requirements
Module: vga_line_arbiter

Interface
REQ-001 SHALL have parameter: DEPTH, 8, write-FIFO entries; power of two, 2..16.
REQ-002 SHALL have port: clk  in  1  single clock, all logic posedge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: rd_req  in  1  VGA-side pixel fetch request; real-time, never stalled.
REQ-005 SHALL have port: rd_addr  in  10  fetch address, {line-half bit, 9-bit x}.
REQ-006 SHALL have port: rd_data  out  15  fetched pixel, held until the next fetch completes.
REQ-007 SHALL have port: rd_valid  out  1  one-cycle pulse when rd_data is updated.
REQ-008 SHALL have port: wr_valid, wr_addr[9:0], wr_data[14:0]  in  PPU-side pixel write.
REQ-009 SHALL have port: wr_ready  out  1  FIFO can accept a write this cycle.
REQ-010 SHALL have port: ram_addr[9:0], ram_wdata[14:0], ram_we  out  single-port line-RAM control.
REQ-011 SHALL have port: ram_rdata  in  15  line-RAM read data, one-cycle synchronous latency.
REQ-012 SHALL have port: fifo_level  out  5  current FIFO occupancy, 0..DEPTH.
REQ-013 SHALL have port: stall_count  out  16  write-stall statistics (see Configuration).

Function
REQ-014 SHALL grant the RAM to the read in any cycle with rd_req=1: ram_addr=rd_addr, ram_we=0; combinational, same cycle.
REQ-015 SHALL, when rd_req=0 and FIFO non-empty, pop the FIFO head: ram_addr/ram_wdata from the head entry, ram_we=1, same cycle.
REQ-016 SHALL drive ram_we=0 and ram_addr=0 when rd_req=0 and FIFO empty.
REQ-017 SHALL register ram_rdata into rd_data on the edge ending cycle N+1 for a read issued in cycle N; rd_valid=1 during cycle N+2 only.
REQ-018 SHALL accept back-to-back reads every cycle with rd_valid asserting every cycle, two cycles later.
REQ-019 SHALL drive wr_ready = (fifo_level < DEPTH), from registered state only; no dependency on rd_req.
REQ-020 SHALL push on wr_valid && wr_ready; a simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-021 SHALL, when full, refuse a push even if a pop occurs in the same cycle.
REQ-022 SHALL commit writes to RAM strictly in acceptance order.
REQ-023 SHALL NOT forward FIFO contents to reads; a read of an address with a pending write returns RAM contents.
REQ-024 SHALL wrap FIFO read/write pointers modulo DEPTH with no gap or duplicate entry.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, set fifo_level=0, wr_ready=1 next cycle, rd_data=0, rd_valid=0, stall_count=0, and discard all pending writes.
REQ-026 SHALL drop a read in flight at reset: no rd_valid after reset deasserts.
REQ-027 SHALL ignore rd_req and wr_valid while reset=1; ram_we=0 during reset.

Configuration
REQ-028 SHALL use macro VGA_LINEARB_STATS_EN.
REQ-029 SHALL, with VGA_LINEARB_STATS_EN defined, increment stall_count each cycle wr_valid=1 && wr_ready=0, saturating at 16'hFFFF.
REQ-030 SHALL, without VGA_LINEARB_STATS_EN, tie stall_count to 0 and instantiate no counter.

Verification
REQ-031 SHALL cover: reset, rd_req=1 addr 0x205 for one cycle, ram_rdata=0x1234 next cycle -> rd_valid pulse two cycles after request, rd_data=0x1234 held afterward.
REQ-032 SHALL cover: 3 writes with rd_req=0 -> ram_we pulses in the 3 cycles after each push, in order, fifo_level returns to 0.
REQ-033 SHALL cover: rd_req held 1, DEPTH=8, 10 writes offered -> 8 accepted, wr_ready=0, ram_we never 1, stall_count=2 (stats on) or 0 (off).
REQ-034 SHALL cover: full FIFO, rd_req drops -> one pop per cycle, wr_ready=1 the cycle after first pop, order preserved.
REQ-035 SHALL cover: 5 entries pending and read in flight, reset pulse -> fifo_level=0, no ram_we, no rd_valid afterward.
REQ-036 SHALL cover: 20 wraps of the FIFO with random rd_req gaps -> RAM model matches golden write sequence exactly.

Source files
------------

// File: rtl/vga_line_arbiter.sv
// Line-RAM arbiter: VGA pixel fetches always own the single RAM port; PPU writes queue in a FIFO and drain in idle cycles.
// Latency: read data appears in rd_data two cycles after rd_req (rd_valid pulse); a queued write reaches RAM in the first cycle without rd_req.
// Backpressure: reads are never stalled; wr_ready drops when the FIFO is full. Optional VGA_LINEARB_STATS_EN adds a saturating write-stall counter.
module vga_line_arbiter #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [9:0]  rd_addr,
  output logic [14:0] rd_data,
  output logic        rd_valid,
  input  logic        wr_valid,
  input  logic [9:0]  wr_addr,
  input  logic [14:0] wr_data,
  output logic        wr_ready,
  output logic [9:0]  ram_addr,
  output logic [14:0] ram_wdata,
  output logic        ram_we,
  input  logic [14:0] ram_rdata,
  output logic [4:0]  fifo_level,
  output logic [15:0] stall_count
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  typedef struct packed {
    logic [9:0]  addr;
    logic [14:0] data;
  } wr_ent_t;

  wr_ent_t        fifo_q [DEPTH];
  wr_ent_t        fifo_d [DEPTH];
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [4:0]     level_q, level_d;
  logic           rd_pend_q, rd_pend_d;
  logic           rd_valid_q, rd_valid_d;
  logic [14:0]    rd_data_q, rd_data_d;

  logic           rd_grant;
  logic           push;
  logic           pop;

  // Full flag comes from registered occupancy only, so the PPU side never sees a combinational path from rd_req.
  assign wr_ready   = (level_q < DEPTH_L);
  assign fifo_level = level_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

  // RAM port arbitration: fetch wins outright, otherwise drain the FIFO head; reset masks both requesters.
  always_comb begin
    rd_grant  = rd_req && !reset;
    push      = wr_valid && wr_ready && !reset;
    pop       = !reset && !rd_req && (level_q != 5'd0);
    ram_we    = pop;
    ram_addr  = '0;
    ram_wdata = '0;
    if (rd_grant) begin
      ram_addr = rd_addr;
    end else if (pop) begin
      ram_addr  = fifo_q[rptr_q].addr;
      ram_wdata = fifo_q[rptr_q].data;
    end
  end

  // Next-state for FIFO storage, pointers, occupancy and the two-stage fetch return pipeline.
  always_comb begin
    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    if (push) begin
      fifo_d[wptr_q] = '{addr: wr_addr, data: wr_data};
      wptr_d         = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    level_d    = level_q + 5'(push) - 5'(pop);
    // RAM data is valid the cycle after the fetch; capture it then and flag it the following cycle.
    rd_pend_d  = rd_grant;
    rd_valid_d = rd_pend_q;
    rd_data_d  = rd_pend_q ? ram_rdata : rd_data_q;
  end

  // Control state register; reset discards queued writes and any fetch still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      rd_pend_q  <= rd_pend_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // FIFO payload storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

`ifdef VGA_LINEARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  // Count cycles where the PPU offers a write that the full FIFO refuses; hold at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (wr_valid && !wr_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_vga_line_arbiter.sv
// Bench for vga_line_arbiter: directed scenarios plus a randomized run against a queue-based model.
// A behavioural line RAM with one-cycle read latency sits on the RAM port.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
module tb_vga_line_arbiter;

  localparam int DEPTH = 8;
`ifdef VGA_LINEARB_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req;
  logic [9:0]  rd_addr;
  logic [14:0] rd_data;
  logic        rd_valid;
  logic        wr_valid;
  logic [9:0]  wr_addr;
  logic [14:0] wr_data;
  logic        wr_ready;
  logic [9:0]  ram_addr;
  logic [14:0] ram_wdata;
  logic        ram_we;
  logic [14:0] ram_rdata;
  logic [4:0]  fifo_level;
  logic [15:0] stall_count;

  logic        bd_clr;
  logic [14:0] ram_mem   [1024];
  logic [14:0] committed [1024];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Line RAM: synchronous read, write port driven by the arbiter; bd_clr preloads known contents.
  always @(posedge clk) begin
    if (bd_clr) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= '0;
      ram_mem[10'h205] <= 15'h1234;
    end else if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= ram_mem[ram_addr];
  end

  vga_line_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .fifo_level(fifo_level), .stall_count(stall_count)
  );

  task automatic drive(input logic rst, input logic rr, input logic [9:0] ra,
                       input logic wv, input logic [9:0] wa, input logic [14:0] wd);
    @(posedge clk); #1;
    reset = rst; rd_req = rr; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
    #2;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 1024; i++) committed[i] = '0;
    committed[10'h205] = 15'h1234;
    drive(1'b1, 1'b1, 10'h205, 1'b1, 10'h003, 15'h0005);
    bd_clr = 1'b0;
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b exp=0", ram_we); end
    drive(1'b1, 1'b1, 10'h205, 1'b1, 10'h003, 15'h0005);
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", wr_ready); end
    total++; if (rd_data !== 15'h0) begin bad++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
    total++; if (stall_count !== 16'h0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_count); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_we2 got=%0b exp=0", ram_we); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 15'h0);
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_ignored_rd cyc=%0d got=%0b exp=0", k, rd_valid); end
    end
  endtask

  task automatic test_read;
    drive(1'b0, 1'b1, 10'h205, 1'b0, 10'h0, 15'h0);
    total++; if (ram_addr !== 10'h205) begin bad++; $display("FAIL read_addr got=%0h exp=205", ram_addr); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL read_we got=%0b exp=0", ram_we); end
    drive(1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 15'h0);
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL read_valid_n1 got=%0b exp=0", rd_valid); end
    drive(1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 15'h0);
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL read_valid_n2 got=%0b exp=1", rd_valid); end
    total++; if (rd_data !== 15'h1234) begin bad++; $display("FAIL read_data_n2 got=%0h exp=1234", rd_data); end
    drive(1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 15'h0);
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL read_valid_n3 got=%0b exp=0", rd_valid); end
    total++; if (rd_data !== 15'h1234) begin bad++; $display("FAIL read_data_hold got=%0h exp=1234", rd_data); end
  endtask

  task automatic test_three_writes;
    logic [9:0]  wa [3];
    logic [14:0] wd [3];
    wa[0] = 10'h010; wa[1] = 10'h011; wa[2] = 10'h012;
    wd[0] = 15'h0111; wd[1] = 15'h0222; wd[2] = 15'h0333;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(1'b0, 1'b0, 10'h0, 1'b1, wa[k], wd[k]);
      else       drive(1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 15'h0);
      if (k == 0 || k == 4) begin
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL wr3_idle cyc=%0d got=%0b exp=0", k, ram_we); end
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL wr3_level cyc=%0d got=%0d exp=0", k, fifo_level); end
      end else begin
        total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL wr3_we cyc=%0d got=%0b exp=1", k, ram_we); end
        total++; if (ram_addr !== wa[k-1]) begin bad++; $display("FAIL wr3_addr cyc=%0d got=%0h exp=%0h", k, ram_addr, wa[k-1]); end
        total++; if (ram_wdata !== wd[k-1]) begin bad++; $display("FAIL wr3_data cyc=%0d got=%0h exp=%0h", k, ram_wdata, wd[k-1]); end
        total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL wr3_level cyc=%0d got=%0d exp=1", k, fifo_level); end
        committed[wa[k-1]] = wd[k-1];
      end
    end
  endtask

  task automatic test_full_and_drain;
    logic [9:0]  qa [$];
    logic [14:0] qd [$];
    int          lvl;
    lvl = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 10'h000, 1'b1, 10'(10'h100 + i), 15'(15'h4000 + i));
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL full_we cyc=%0d got=%0b exp=0", i, ram_we); end
      total++; if (wr_ready !== (lvl < DEPTH)) begin bad++; $display("FAIL full_ready cyc=%0d got=%0b exp=%0b", i, wr_ready, lvl < DEPTH); end
      total++; if (fifo_level !== 5'(lvl)) begin bad++; $display("FAIL full_level cyc=%0d got=%0d exp=%0d", i, fifo_level, lvl); end
      if (lvl < DEPTH) begin
        qa.push_back(10'(10'h100 + i)); qd.push_back(15'(15'h4000 + i)); lvl++;
      end
    end
    // Read drops; a write offered while full must be refused even though a pop happens.
    drive(1'b0, 1'b0, 10'h0, 1'b1, 10'h3FF, 15'h7FFF);
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_ready_end got=%0b exp=0", wr_ready); end
    total++; if (fifo_level !== 5'(DEPTH)) begin bad++; $display("FAIL full_level_end got=%0d exp=%0d", fifo_level, DEPTH); end
    total++; if (stall_count !== 16'(2 * STATS_ON)) begin bad++; $display("FAIL full_stall got=%0d exp=%0d", stall_count, 2 * STATS_ON); end
    for (int k = 0; k < DEPTH; k++) begin
      if (k > 0) begin
        drive(1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 15'h0);
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL drain_ready k=%0d got=%0b exp=1", k, wr_ready); end
        total++; if (fifo_level !== 5'(DEPTH - k)) begin bad++; $display("FAIL drain_level k=%0d got=%0d exp=%0d", k, fifo_level, DEPTH - k); end
      end
      if (k == 1) begin
        total++; if (stall_count !== 16'(3 * STATS_ON)) begin bad++; $display("FAIL drain_stall got=%0d exp=%0d", stall_count, 3 * STATS_ON); end
      end
      total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL drain_we k=%0d got=%0b exp=1", k, ram_we); end
      total++; if (ram_addr !== qa[0]) begin bad++; $display("FAIL drain_addr k=%0d got=%0h exp=%0h", k, ram_addr, qa[0]); end
      total++; if (ram_wdata !== qd[0]) begin bad++; $display("FAIL drain_data k=%0d got=%0h exp=%0h", k, ram_wdata, qd[0]); end
      committed[qa[0]] = qd[0];
      void'(qa.pop_front()); void'(qd.pop_front());
    end
    drive(1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 15'h0);
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL drain_done_we got=%0b exp=0", ram_we); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL drain_done_level got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_reset_inflight;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 10'h205, 1'b1, 10'(10'h200 + i), 15'(15'h1000 + i));
    drive(1'b0, 1'b1, 10'h205, 1'b0, 10'h0, 15'h0);
    total++; if (fifo_level !== 5'd5) begin bad++; $display("FAIL infl_level got=%0d exp=5", fifo_level); end
    drive(1'b1, 1'b0, 10'h0, 1'b1, 10'h2AA, 15'h2AAA);
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL infl_rst_we got=%0b exp=0", ram_we); end
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 10'h0, 1'b0, 10'h0, 15'h0);
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL infl_valid k=%0d got=%0b exp=0", k, rd_valid); end
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL infl_we k=%0d got=%0b exp=0", k, ram_we); end
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL infl_level k=%0d got=%0d exp=0", k, fifo_level); end
      if (k == 0) begin
        total++; if (rd_data !== 15'h0) begin bad++; $display("FAIL infl_rd_data got=%0h exp=0", rd_data); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL infl_ready got=%0b exp=1", wr_ready); end
      end
    end
  endtask

  task automatic test_random_wraps;
    logic [9:0]  pa [$];
    logic [14:0] pd [$];
    logic        rr, wv, h1v, h2v, nv, exp_ready;
    logic [9:0]  ra, wa;
    logic [14:0] wd, h1d, h2d, nd;
    int          accepted, cycles, idle, diffs;
    accepted = 0; cycles = 0; idle = 0;
    h1v = 1'b0; h2v = 1'b0; h1d = '0; h2d = '0;
    while (cycles < 4000 && !(accepted >= 20 * DEPTH && pa.size() == 0 && idle >= 3)) begin
      if (accepted >= 20 * DEPTH) begin
        rr = 1'b0; wv = 1'b0; idle = (pa.size() == 0) ? idle + 1 : 0;
      end else begin
        rr = ($urandom_range(0, 99) < 40);
        wv = ($urandom_range(0, 99) < 75);
      end
      ra = 10'($urandom_range(0, 1023));
      wa = 10'($urandom_range(0, 1023));
      wd = 15'($urandom_range(0, 32767));
      drive(1'b0, rr, ra, wv, wa, wd);
      cycles++;
      exp_ready = (pa.size() < DEPTH);
      total++; if (fifo_level !== 5'(pa.size())) begin bad++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", cycles, fifo_level, pa.size()); end
      total++; if (wr_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", cycles, wr_ready, exp_ready); end
      total++; if (rd_valid !== h2v) begin bad++; $display("FAIL rnd_rd_valid cyc=%0d got=%0b exp=%0b", cycles, rd_valid, h2v); end
      if (h2v) begin
        total++; if (rd_data !== h2d) begin bad++; $display("FAIL rnd_rd_data cyc=%0d got=%0h exp=%0h", cycles, rd_data, h2d); end
      end
      nv = 1'b0; nd = '0;
      if (rr) begin
        total++; if (ram_we !== 1'b0 || ram_addr !== ra) begin bad++; $display("FAIL rnd_read_port cyc=%0d got=we%0b/%0h exp=we0/%0h", cycles, ram_we, ram_addr, ra); end
        nv = 1'b1; nd = committed[ra];
      end else if (pa.size() > 0) begin
        total++; if (ram_we !== 1'b1 || ram_addr !== pa[0] || ram_wdata !== pd[0]) begin
          bad++; $display("FAIL rnd_write_port cyc=%0d got=we%0b/%0h/%0h exp=we1/%0h/%0h", cycles, ram_we, ram_addr, ram_wdata, pa[0], pd[0]);
        end
        committed[pa[0]] = pd[0];
        void'(pa.pop_front()); void'(pd.pop_front());
      end else begin
        total++; if (ram_we !== 1'b0 || ram_addr !== 10'h0) begin bad++; $display("FAIL rnd_idle_port cyc=%0d got=we%0b/%0h exp=we0/0", cycles, ram_we, ram_addr); end
      end
      if (wv && exp_ready) begin
        pa.push_back(wa); pd.push_back(wd); accepted++;
      end
      h2v = h1v; h2d = h1d; h1v = nv; h1d = nd;
    end
    total++; if (accepted < 20 * DEPTH || pa.size() != 0) begin bad++; $display("FAIL rnd_budget accepted=%0d pending=%0d exp>=%0d/0", accepted, pa.size(), 20 * DEPTH); end
    diffs = 0;
    for (int i = 0; i < 1024; i++) if (ram_mem[i] !== committed[i]) diffs++;
    total++; if (diffs != 0) begin bad++; $display("FAIL rnd_ram_image got=%0d differing words exp=0", diffs); end
  endtask

  initial begin
    reset = 1'b1; rd_req = 1'b1; rd_addr = 10'h205; wr_valid = 1'b1;
    wr_addr = 10'h003; wr_data = 15'h0005; bd_clr = 1'b1;
    test_reset();
    test_read();
    test_three_writes();
    test_full_and_drain();
    test_reset_inflight();
    test_random_wraps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
